pixel_location_tracker: RTL and testbench
=========================================

PIXEL_LOCATION_TRACKER -- requirements
Module: pixel_location_tracker

Interface
REQ-001 Parameter LOC_W, default 11, SHALL set width of x, y, line_len.
REQ-002 Parameter FRAME_W, default 16, SHALL set width of frame.
REQ-003 Parameters HS_POL and VS_POL, default 1, SHALL give the active level of hsync and vsync.
REQ-004 Parameter EDGE_MODE, default 1, SHALL select the sync event type: 1 = assertion edge, 0 = active level.
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 en  input  1  pixel beat; sync inputs are sampled and counters advance only when en=1.
REQ-008 hsync / vsync  input  1 each  raw line and frame sync.
REQ-009 x, y  output  LOC_W each  registered column and row of the current beat.
REQ-010 frame  output  FRAME_W  registered frame count.
REQ-011 line_len  output  LOC_W  beat count of the last completed line.
REQ-012 sof, eol  output  1 each  one-cycle start-of-frame and end-of-line pulses.
REQ-013 locked  output  1  timing is stable.
REQ-014 lock_lost  output  1  one-cycle pulse when locked drops.
REQ-015 x_ovf  output  1  sticky flag: x saturated.

Function
REQ-016 Active sync SHALL be computed as (sync == POL); in EDGE_MODE=1 an event SHALL be active & ~prev, where prev is the active value captured on the previous en beat.
REQ-017 On an en beat with a vsync event, the block SHALL set x<=0, y<=0, frame<=frame+1 (modulo 2^FRAME_W) and pulse sof.
REQ-018 On an en beat with an hsync event and no vsync event, the block SHALL set x<=0, y<=y+1 (saturating at 2^LOC_W-1), line_len<=x+1 (saturating) and pulse eol.
REQ-019 When vsync and hsync events coincide, vsync SHALL take priority and eol SHALL NOT pulse.
REQ-020 On an en beat with no event, x SHALL increment; at 2^LOC_W-1 it SHALL hold and set x_ovf.
REQ-021 When en=0, x, y, frame, prev and the FSM SHALL hold, and sof, eol and lock_lost SHALL be 0.
REQ-022 Outputs SHALL have 1-cycle latency from the en beat that causes them.
REQ-023 The lock FSM SHALL have states SEARCH, MEASURE, VERIFY and LOCKED, with locked=1 only in LOCKED.
REQ-024 SEARCH SHALL go to MEASURE on a vsync event.
REQ-025 MEASURE SHALL capture ref_len=x+1 on the first hsync event and go to VERIFY.
REQ-026 In VERIFY, a vsync event SHALL go to LOCKED, and an hsync event with x+1 != ref_len SHALL go to SEARCH.
REQ-027 In LOCKED, an hsync event with x+1 != ref_len SHALL go to SEARCH and pulse lock_lost.
REQ-028 x_ovf in LOCKED SHALL also go to SEARCH and pulse lock_lost.
REQ-029 A vsync event in VERIFY or LOCKED SHALL NOT compare line length for that beat.

Reset
REQ-030 While reset_n=0, the block SHALL clear x, y, frame, line_len, sof, eol, lock_lost, x_ovf, locked and ref_len, and SHALL force the FSM to SEARCH.
REQ-031 Reset SHALL set both prev registers to 1, so a sync held active through reset produces no event in EDGE_MODE=1.
REQ-032 Reset asserted mid-frame SHALL take priority over en and any sync event in the same cycle.

Structure
REQ-033 Package loc_pkg SHALL hold the FSM state enum (lock_state_t) and the LOC_W and FRAME_W default constants.
REQ-034 A sub-module sync_event_detect (polarity, edge/level mode, en-gated prev register) SHALL be instantiated once per sync input.
REQ-035 Counter and FSM logic SHALL reside in pixel_location_tracker.

Verification
REQ-036 Stimulus: reset, then en=1 with lines of 8 beats (hsync on beat 8) and a vsync after 4 lines. Required: eol every 8 beats, line_len=8, sof once, frame=1, y=0 after sof.
REQ-037 Stimulus: keep REQ-036 timing for 2 frames. Required: locked=1 one cycle after the second vsync beat; then a 7-beat line gives lock_lost for one cycle and locked=0.
REQ-038 Stimulus: EDGE_MODE=1 with hsync held high for 3 beats. Required: exactly one eol. With EDGE_MODE=0 and the same stimulus: three eols, y advances 3.
REQ-039 Stimulus: hsync and vsync asserted on the same beat. Required: sof=1, eol=0, y=0, x=0.
REQ-040 Stimulus: LOC_W=4, 20 beats with no hsync. Required: x holds at 15 and x_ovf=1.
REQ-041 Stimulus: en toggled 1/0 each cycle; reset_n pulsed low mid-line with hsync high, then released. Required: counters advance only on en beats; no eol after reset; all outputs 0 while reset_n=0.

Source files
------------

// File: rtl/loc_pkg.sv
// Shared types and default widths for the pixel location tracker.
package loc_pkg;

  localparam int LOC_W_DEF   = 11;
  localparam int FRAME_W_DEF = 16;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } lock_state_t;

endpackage

// File: rtl/sync_event_detect.sv
// Turns a raw sync input into a per-beat event: polarity-normalised, then
// either the assertion edge or the plain active level.
module sync_event_detect #(
  parameter int POL       = 1,
  parameter int EDGE_MODE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_sync,
  output logic o_event
);

  logic w_active;
  logic r_prev;

  assign w_active = (i_sync == POL[0]);

  // prev resets high so a sync already active when reset releases is not an edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev <= 1'b1;
    end else if (i_en) begin
      r_prev <= w_active;
    end
  end

  assign o_event = i_en & ((EDGE_MODE != 0) ? (w_active & ~r_prev) : w_active);

endmodule

// File: rtl/pixel_location_tracker.sv
// Tracks column/row/frame of a pixel stream from hsync/vsync and locks onto
// a stable line length; lock_lost pulses when the timing breaks.
module pixel_location_tracker
  import loc_pkg::*;
#(
  parameter int LOC_W     = LOC_W_DEF,
  parameter int FRAME_W   = FRAME_W_DEF,
  parameter int HS_POL    = 1,
  parameter int VS_POL    = 1,
  parameter int EDGE_MODE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               hsync,
  input  logic               vsync,
  output logic [LOC_W-1:0]   x,
  output logic [LOC_W-1:0]   y,
  output logic [FRAME_W-1:0] frame,
  output logic [LOC_W-1:0]   line_len,
  output logic               sof,
  output logic               eol,
  output logic               locked,
  output logic               lock_lost,
  output logic               x_ovf,
  output logic [1:0]         state_dbg
);

  localparam logic [LOC_W-1:0] LOC_MAX = '1;

  logic               w_h_ev;
  logic               w_v_ev;
  logic               w_h_only;
  logic               w_x_max;
  logic               w_sat;
  logic               w_len_bad;
  logic [LOC_W-1:0]   w_len;
  logic [LOC_W-1:0]   w_y_inc;

  logic [LOC_W-1:0]   r_x;
  logic [LOC_W-1:0]   r_y;
  logic [FRAME_W-1:0] r_frame;
  logic [LOC_W-1:0]   r_line_len;
  logic [LOC_W-1:0]   r_ref_len;
  logic               r_sof;
  logic               r_eol;
  logic               r_x_ovf;
  logic               r_lock_lost;

  lock_state_t        r_state;
  lock_state_t        w_state_nxt;
  logic               w_lost;
  logic               w_capture;

  sync_event_detect #(.POL(HS_POL), .EDGE_MODE(EDGE_MODE)) u_hs_det (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (en),
    .i_sync  (hsync),
    .o_event (w_h_ev)
  );

  sync_event_detect #(.POL(VS_POL), .EDGE_MODE(EDGE_MODE)) u_vs_det (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (en),
    .i_sync  (vsync),
    .o_event (w_v_ev)
  );

  assign w_h_only  = w_h_ev & ~w_v_ev;
  assign w_x_max   = (r_x == LOC_MAX);
  assign w_len     = w_x_max ? LOC_MAX : r_x + 1'b1;
  assign w_y_inc   = (r_y == LOC_MAX) ? LOC_MAX : r_y + 1'b1;
  // saturation beat: en with no event while x already at its ceiling
  assign w_sat     = en & ~w_v_ev & ~w_h_ev & w_x_max;
  assign w_len_bad = w_h_only & (w_len != r_ref_len);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_frame    <= '0;
      r_line_len <= '0;
      r_sof      <= 1'b0;
      r_eol      <= 1'b0;
      r_x_ovf    <= 1'b0;
    end else begin
      r_sof <= 1'b0;
      r_eol <= 1'b0;
      if (w_v_ev) begin
        r_x     <= '0;
        r_y     <= '0;
        r_frame <= r_frame + 1'b1;
        r_sof   <= 1'b1;
      end else if (w_h_ev) begin
        r_x        <= '0;
        r_y        <= w_y_inc;
        r_line_len <= w_len;
        r_eol      <= 1'b1;
      end else if (en) begin
        if (w_x_max) begin
          r_x_ovf <= 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lost      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_v_ev) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (w_h_only) begin
          w_capture   = 1'b1;
          w_state_nxt = VERIFY;
        end
      end
      VERIFY: begin
        if (w_v_ev) w_state_nxt = LOCKED;
        else if (w_len_bad) w_state_nxt = SEARCH;
      end
      LOCKED: begin
        if (w_len_bad | w_sat) begin
          w_state_nxt = SEARCH;
          w_lost      = 1'b1;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= SEARCH;
      r_ref_len   <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_lost <= w_lost;
      if (w_capture) r_ref_len <= w_len;
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign frame     = r_frame;
  assign line_len  = r_line_len;
  assign sof       = r_sof;
  assign eol       = r_eol;
  assign x_ovf     = r_x_ovf;
  assign lock_lost = r_lock_lost;
  assign locked    = (r_state == LOCKED);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_pixel_location_tracker.sv
// Bench for pixel_location_tracker: three configurations share one stimulus
// stream and are checked every beat against a per-configuration model.
module tb_pixel_location_tracker;

  logic clk;
  logic reset_n;
  logic en;
  logic hsync;
  logic vsync;

  logic [10:0] x0, y0, ll0;
  logic [15:0] fr0;
  logic        sof0, eol0, lk0, lost0, ovf0;
  logic [1:0]  st0;
  logic [10:0] x1, y1, ll1;
  logic [15:0] fr1;
  logic        sof1, eol1, lk1, lost1, ovf1;
  logic [1:0]  st1;
  logic [3:0]  x2, y2, ll2;
  logic [15:0] fr2;
  logic        sof2, eol2, lk2, lost2, ovf2;
  logic [1:0]  st2;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pixel_location_tracker u_main (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync),
    .x(x0), .y(y0), .frame(fr0), .line_len(ll0), .sof(sof0), .eol(eol0),
    .locked(lk0), .lock_lost(lost0), .x_ovf(ovf0), .state_dbg(st0)
  );

  pixel_location_tracker #(.EDGE_MODE(0)) u_lvl (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync),
    .x(x1), .y(y1), .frame(fr1), .line_len(ll1), .sof(sof1), .eol(eol1),
    .locked(lk1), .lock_lost(lost1), .x_ovf(ovf1), .state_dbg(st1)
  );

  pixel_location_tracker #(.LOC_W(4)) u_small (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync),
    .x(x2), .y(y2), .frame(fr2), .line_len(ll2), .sof(sof2), .eol(eol2),
    .locked(lk2), .lock_lost(lost2), .x_ovf(ovf2), .state_dbg(st2)
  );

  // ---------------- reference model ----------------
  // phase: 0 hunting for a frame start, 1 waiting for the first line,
  // 2 checking lines against the reference, 3 locked
  typedef struct {
    int x, y, frame, line_len, ref_len;
    int sof, eol, lost, ovf, phase;
    int hprev, vprev, edge_m, xmax;
  } mdl_t;

  mdl_t m[3];
  int   n_checks;
  int   n_errors;
  int   eol_n[3];
  int   sof_n[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input int i, input bit rn, input bit e, input bit hs, input bit vs);
    mdl_t s;
    int   len;
    bit   hev, vev, sat, len_bad;
    s = m[i];
    if (!rn) begin
      s.x = 0; s.y = 0; s.frame = 0; s.line_len = 0; s.ref_len = 0;
      s.sof = 0; s.eol = 0; s.lost = 0; s.ovf = 0; s.phase = 0;
      s.hprev = 1; s.vprev = 1;
    end else begin
      s.sof = 0; s.eol = 0; s.lost = 0;
      if (e) begin
        hev = (s.edge_m != 0) ? (hs && s.hprev == 0) : hs;
        vev = (s.edge_m != 0) ? (vs && s.vprev == 0) : vs;
        s.hprev = int'(hs);
        s.vprev = int'(vs);
        len = (s.x + 1 > s.xmax) ? s.xmax : s.x + 1;
        sat = 0;
        len_bad = hev && !vev && (len != s.ref_len);
        if (vev) begin
          s.x = 0; s.y = 0; s.frame = (s.frame + 1) % 65536; s.sof = 1;
        end else if (hev) begin
          s.line_len = len;
          s.y = (s.y + 1 > s.xmax) ? s.xmax : s.y + 1;
          s.x = 0; s.eol = 1;
        end else if (s.x == s.xmax) begin
          s.ovf = 1; sat = 1;
        end else begin
          s.x = s.x + 1;
        end
        if (s.phase == 0) begin
          if (vev) s.phase = 1;
        end else if (s.phase == 1) begin
          if (hev && !vev) begin s.ref_len = len; s.phase = 2; end
        end else if (s.phase == 2) begin
          if (vev) s.phase = 3;
          else if (len_bad) s.phase = 0;
        end else begin
          if (len_bad || sat) begin s.phase = 0; s.lost = 1; end
        end
      end
    end
    m[i] = s;
  endtask

  task automatic cmp(input string nm, input int i, input logic [31:0] gx, input logic [31:0] gy,
                     input logic [31:0] gf, input logic [31:0] gl, input logic gs, input logic ge,
                     input logic gk, input logic gt, input logic go);
    check({nm, ".x"}, gx, m[i].x);
    check({nm, ".y"}, gy, m[i].y);
    check({nm, ".frame"}, gf, m[i].frame);
    check({nm, ".line_len"}, gl, m[i].line_len);
    check({nm, ".sof"}, 32'(gs), m[i].sof);
    check({nm, ".eol"}, 32'(ge), m[i].eol);
    check({nm, ".locked"}, 32'(gk), (m[i].phase == 3) ? 1 : 0);
    check({nm, ".lock_lost"}, 32'(gt), m[i].lost);
    check({nm, ".x_ovf"}, 32'(go), m[i].ovf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic beat(input bit e, input bit hs, input bit vs);
    en = e; hsync = hs; vsync = vs;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, reset_n, e, hs, vs);
    @(negedge clk);
    cmp("main", 0, 32'(x0), 32'(y0), 32'(fr0), 32'(ll0), sof0, eol0, lk0, lost0, ovf0);
    cmp("lvl", 1, 32'(x1), 32'(y1), 32'(fr1), 32'(ll1), sof1, eol1, lk1, lost1, ovf1);
    cmp("small", 2, 32'(x2), 32'(y2), 32'(fr2), 32'(ll2), sof2, eol2, lk2, lost2, ovf2);
    eol_n[0] += int'(eol0); eol_n[1] += int'(eol1); eol_n[2] += int'(eol2);
    sof_n[0] += int'(sof0); sof_n[1] += int'(sof1); sof_n[2] += int'(sof2);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 3; i++) begin eol_n[i] = 0; sof_n[i] = 0; end
  endtask

  task automatic line(input int n, input bit gaps);
    for (int b = 1; b <= n; b++) begin
      if (gaps && $urandom_range(0, 4) == 0)
        beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      beat(1'b1, b == n, 1'b0);
    end
  endtask

  task automatic frame_end();
    beat(1'b1, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0;
    m[0].edge_m = 1; m[0].xmax = 2047;
    m[1].edge_m = 0; m[1].xmax = 2047;
    m[2].edge_m = 1; m[2].xmax = 15;
    en = 1'b0; hsync = 1'b0; vsync = 1'b0; reset_n = 1'b0;
    clr_counts();

    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    check("rst_x", 32'(x0), 0);
    check("rst_frame", 32'(fr0), 0);
    check("rst_locked", 32'(lk0), 0);
    reset_n = 1'b1;

    // four 8-beat lines then a frame start
    clr_counts();
    for (int l = 0; l < 4; l++) line(8, 1'b0);
    check("eol_cnt", eol_n[0], 4);
    check("line_len", 32'(ll0), 8);
    frame_end();
    check("sof", 32'(sof0), 1);
    check("sof_cnt", sof_n[0], 1);
    check("frame_one", 32'(fr0), 1);
    check("y_after_sof", 32'(y0), 0);

    // second frame locks, a short line breaks it
    for (int l = 0; l < 4; l++) line(8, 1'b0);
    check("pre_lock", 32'(lk0), 0);
    frame_end();
    check("locked", 32'(lk0), 1);
    line(7, 1'b0);
    check("lock_lost", 32'(lost0), 1);
    check("unlocked", 32'(lk0), 0);
    beat(1'b1, 1'b0, 1'b0);
    check("lost_one_cycle", 32'(lost0), 0);

    // hsync held for three beats: edge vs level
    frame_end();
    beat(1'b1, 1'b0, 1'b0);
    clr_counts();
    for (int k = 0; k < 3; k++) beat(1'b1, 1'b1, 1'b0);
    check("edge_eol_cnt", eol_n[0], 1);
    check("lvl_eol_cnt", eol_n[1], 3);
    check("lvl_y", 32'(y1), 3);
    check("edge_y", 32'(y0), 1);
    beat(1'b1, 1'b0, 1'b0);

    // coincident syncs
    beat(1'b1, 1'b1, 1'b1);
    check("both_sof", 32'(sof0), 1);
    check("both_eol", 32'(eol0), 0);
    check("both_y", 32'(y0), 0);
    check("both_x", 32'(x0), 0);

    // x saturation on the narrow instance
    for (int k = 0; k < 20; k++) beat(1'b1, 1'b0, 1'b0);
    check("small_x", 32'(x2), 15);
    check("small_ovf", 32'(ovf2), 1);
    check("main_x", 32'(x0), 20);
    check("main_ovf", 32'(ovf0), 0);

    // en gating, then reset mid-line with hsync held high
    for (int k = 0; k < 3; k++) begin beat(1'b1, 1'b0, 1'b0); beat(1'b0, 1'b1, 1'b0); end
    check("en_gate_x", 32'(x0), 23);
    reset_n = 1'b0;
    beat(1'b1, 1'b1, 1'b0);
    check("inrst_x", 32'(x0), 0);
    check("inrst_y", 32'(y0), 0);
    check("inrst_frame", 32'(fr0), 0);
    check("inrst_line_len", 32'(ll0), 0);
    check("inrst_eol", 32'(eol0), 0);
    check("inrst_small_ovf", 32'(ovf2), 0);
    beat(1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;
    clr_counts();
    for (int k = 0; k < 3; k++) begin beat(1'b1, 1'b1, 1'b0); beat(1'b0, 1'b1, 1'b0); end
    check("no_eol_after_rst", eol_n[0], 0);
    check("x_after_rst", 32'(x0), 3);

    // randomized frames with occasional bad lines, held syncs, gaps and resets
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        beat(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        reset_n = 1'b1;
      end
      for (int l = 0; l < int'($urandom_range(2, 5)); l++) begin
        line(($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 20)) : 8, 1'b1);
        if ($urandom_range(0, 7) == 0) beat(1'b1, 1'b1, 1'b0);
      end
      beat(1'b1, ($urandom_range(0, 3) == 0), 1'b1);
      if ($urandom_range(0, 7) == 0) beat(1'b1, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
